// File: rtl/icache_pkg.sv
// Shared CPU definitions used by the instruction cache.
// Holds the cache FSM encoding, default geometry and address-field constants.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        FILL
    } icache_state_t;

    localparam int ICACHE_SETS       = 64;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ADDR_W            = 32;
    localparam int WORD_LSB          = 2;

endpackage

// File: rtl/icache_refill.sv
// Instruction cache refill engine.
// Burst read handshake, beat counter and line buffer for one cache line.
module icache_refill
    import cpu_defs::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   miss,
    input  logic [29-$clog2(LINE_WORDS):0]         line_base,
    input  logic                                   rd_rdy,
    input  logic                                   rd_valid,
    input  logic [31:0]                            rd_data,
    input  logic                                   rd_last,
    output icache_state_t                          state,
    output logic                                   rd_req,
    output logic [31:0]                            rd_addr,
    output logic [LINE_WORDS-1:0][31:0]            line_buf
);

    localparam int OFF_W = $clog2(LINE_WORDS);

    icache_state_t    state_d;
    logic [OFF_W-1:0] cnt;
    logic             full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (miss) state_d = REQ;
            REQ:  if (rd_rdy) state_d = DATA;
            DATA: if (rd_valid && rd_last) state_d = FILL;
            FILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_req  = (state == REQ);
        rd_addr = '0;
        if (rd_req) begin
            rd_addr = {line_base, {(OFF_W + WORD_LSB){1'b0}}};
        end
    end

    // Buffer is cleared at miss time so an early rd_last leaves zeros behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            full     <= 1'b0;
            line_buf <= '0;
        end else if (state == IDLE && miss) begin
            cnt      <= '0;
            full     <= 1'b0;
            line_buf <= '0;
        end else if (state == DATA && rd_valid && !full) begin
            line_buf[cnt] <= rd_data;
            cnt           <= cnt + OFF_W'(1);
            if (cnt == {OFF_W{1'b1}}) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, lookup in fetch2.
// Holds tag/valid/data arrays, the fetch2 request register and line fill.
module icache
    import cpu_defs::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    input  logic        is_stall,
    input  logic        inv_all,
    output logic        icache_ready,
    output logic [31:0] icache_data,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    input  logic        rd_last
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - WORD_LSB;

    icache_state_t               state;
    logic                        s2_valid;
    logic [31:2]                 s2_pc;
    logic [OFF_W-1:0]            off;
    logic [IDX_W-1:0]            idx;
    logic [TAG_W-1:0]            tag;
    logic                        hit;
    logic                        inv_pend;
    logic [SETS-1:0]             valid;
    logic [TAG_W-1:0]            tag_arr [SETS];
    logic [LINE_WORDS-1:0][31:0] data_arr [SETS];
    logic [LINE_WORDS-1:0][31:0] line_buf;
    logic                        unused_pc_bits;

    assign unused_pc_bits = ^req_pc[1:0];

    assign off = s2_pc[OFF_W+1:2];
    assign idx = s2_pc[IDX_W+OFF_W+1:OFF_W+2];
    assign tag = s2_pc[31:IDX_W+OFF_W+2];
    assign hit = valid[idx] && (tag_arr[idx] == tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_pc    <= '0;
        end else if (!is_stall && state == IDLE) begin
            s2_valid <= req_valid;
            s2_pc    <= req_pc[31:2];
        end
    end

    // An invalidate seen mid-refill must not let the fill line survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= '0;
            inv_pend <= 1'b0;
        end else begin
            unique case (state)
                IDLE, REQ: if (inv_all) valid <= '0;
                DATA: if (inv_all) inv_pend <= 1'b1;
                FILL: begin
                    if (inv_pend || inv_all) begin
                        valid    <= '0;
                        inv_pend <= 1'b0;
                    end else begin
                        valid[idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tag_arr[idx]  <= tag;
            data_arr[idx] <= line_buf;
        end
    end

    always_comb begin
        icache_ready = 1'b0;
        icache_data  = '0;
        unique case (state)
            IDLE: begin
                icache_ready = !s2_valid || hit;
                if (s2_valid && hit) begin
                    icache_data = data_arr[idx][off];
                end
            end
            FILL: begin
                icache_ready = 1'b1;
                icache_data  = line_buf[off];
            end
            default: ;
        endcase
    end

    icache_refill #(
        .LINE_WORDS(LINE_WORDS)
    ) u_refill (
        .clk      (clk),
        .rst      (rst),
        .miss     (s2_valid && !hit),
        .line_base(s2_pc[31:OFF_W+2]),
        .rd_rdy   (rd_rdy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .state    (state),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .line_buf (line_buf)
    );

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache.
// A line model predicts hit/miss; expected words flow through a scoreboard queue.
module tb_icache;

    localparam int SETS = 64;
    localparam int LW   = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        is_stall;
    logic        inv_all;
    logic        icache_ready;
    logic [31:0] icache_data;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        stall_force;

    int n_chk;
    int n_fail;

    bit          m_valid [SETS];
    logic [21:0] m_tag   [SETS];
    logic [31:0] m_data  [SETS][LW];
    logic [31:0] sb [$];

    // Fetch2 stalls whenever the cache is not ready, like the real pipeline.
    assign is_stall = stall_force || !icache_ready;

    icache #(
        .SETS      (SETS),
        .LINE_WORDS(LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .is_stall    (is_stall),
        .inv_all     (inv_all),
        .icache_ready(icache_ready),
        .icache_data (icache_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_rdy      (rd_rdy),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_last     (rd_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h1C00800) return 32'hA0 + {30'd0, a[3:2]};
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    endtask

    // Called at the negedge of an IDLE miss cycle; serves the burst.
    task automatic serve_miss(input logic [31:0] pc, input int rdy_dly,
                              input int nbeats, input bit inv_mid,
                              input string name);
        int          si;
        int          o;
        int          k;
        bit          held;
        logic [31:0] line [LW];
        logic [31:0] e;
        si = int'(pc[9:4]);
        o  = int'(pc[3:2]);
        for (int w = 0; w < LW; w++) begin
            line[w] = (w < nbeats) ?
                mem_word({pc[31:4], w[1:0], 2'b00}) : 32'h0;
        end
        sb.push_back(line[o]);
        m_tag[si] = pc[31:10];
        for (int w = 0; w < LW; w++) m_data[si][w] = line[w];
        m_valid[si] = !inv_mid;
        if (inv_mid) clear_model();

        n_chk++;
        if (icache_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s miss_ready got %b exp 0", name, icache_ready);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (rd_req !== 1'b1 && k < 10);
        n_chk++;
        if (rd_req !== 1'b1 || rd_addr !== {pc[31:4], 4'h0}) begin
            n_fail++;
            $display("FAIL %s rd_addr got req=%b %h exp req=1 %h",
                     name, rd_req, rd_addr, {pc[31:4], 4'h0});
        end
        held = 1'b1;
        repeat (rdy_dly) begin
            @(negedge clk);
            if (rd_req !== 1'b1) held = 1'b0;
        end
        n_chk++;
        if (!held) begin
            n_fail++;
            $display("FAIL %s rd_req_hold got 0 exp 1", name);
        end
        rd_rdy = 1'b1;
        @(posedge clk);
        #1 rd_rdy = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            rd_valid = 1'b1;
            rd_data  = (b < LW) ? line[b] : (32'hDEAD_0000 | b);
            rd_last  = (b == nbeats - 1);
            inv_all  = inv_mid && (b == 0);
            @(posedge clk);
            #1;
        end
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        rd_data  = '0;
        inv_all  = 1'b0;
        @(negedge clk);
        n_chk++;
        if (icache_ready !== 1'b1 || rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s fill_ready got rdy=%b req=%b exp rdy=1 req=0",
                     name, icache_ready, rd_req);
        end
        e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_chk++;
        if (icache_data !== e) begin
            n_fail++;
            $display("FAIL %s fill_data got %h exp %h", name, icache_data, e);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input int rdy_dly,
                         input int nbeats, input bit inv_mid,
                         input string name);
        int          si;
        int          o;
        bit          hit;
        logic [31:0] e;
        si  = int'(pc[9:4]);
        o   = int'(pc[3:2]);
        hit = m_valid[si] && (m_tag[si] == pc[31:10]);
        if (hit) sb.push_back(m_data[si][o]);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_pc    = pc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_pc    = 32'hFFFF_FFF0;
        @(negedge clk);
        if (hit) begin
            n_chk++;
            if (icache_ready !== 1'b1 || rd_req !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hit_ready got rdy=%b req=%b exp rdy=1 req=0",
                         name, icache_ready, rd_req);
            end
            e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
            n_chk++;
            if (icache_data !== e) begin
                n_fail++;
                $display("FAIL %s hit_data got %h exp %h", name, icache_data, e);
            end
        end else begin
            serve_miss(pc, rdy_dly, nbeats, inv_mid, name);
            if (inv_mid) begin
                // s2 still holds the pc and its line was left invalid
                @(negedge clk);
                serve_miss(pc, 0, LW, 1'b0, {name, "_remiss"});
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if (icache_ready !== 1'b1 || icache_data !== 32'h0 ||
            rd_req !== 1'b0 || rd_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset got rdy=%b data=%h req=%b addr=%h exp 1 0 0 0",
                     icache_ready, icache_data, rd_req, rd_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        fetch(32'h1C00_8008, 2, LW, 1'b0, "cold_miss");
    endtask

    task automatic test_hit();
        fetch(32'h1C00_800C, 0, LW, 1'b0, "hit_a3");
        fetch(32'h1C00_8000, 0, LW, 1'b0, "hit_a0");
    endtask

    task automatic test_conflict();
        fetch(32'h1C00_9008, 1, LW, 1'b0, "conflict_new");
        fetch(32'h1C00_8008, 0, LW, 1'b0, "conflict_back");
    endtask

    task automatic test_stall();
        logic [31:0] e;
        fetch(32'h1C00_8004, 0, LW, 1'b0, "stall_hit");
        e = m_data[0][1];
        stall_force = 1'b1;
        req_valid   = 1'b1;
        req_pc      = 32'h1C00_8000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (icache_ready !== 1'b1 || icache_data !== e) begin
                n_fail++;
                $display("FAIL stall_hold%0d got rdy=%b %h exp rdy=1 %h",
                         c, icache_ready, icache_data, e);
            end
        end
        stall_force = 1'b0;
        req_valid   = 1'b0;
    endtask

    task automatic test_partial();
        fetch(32'h2000_0018, 1, 2, 1'b0, "early_last");
        fetch(32'h2000_0014, 0, LW, 1'b0, "early_hit");
        fetch(32'h2000_001C, 0, LW, 1'b0, "early_zero");
        fetch(32'h3000_0020, 0, 6, 1'b0, "extra_beats");
        fetch(32'h3000_0024, 0, LW, 1'b0, "extra_hit");
    endtask

    task automatic test_inv();
        fetch(32'h4000_0008, 0, LW, 1'b1, "inv_data");
        fetch(32'h4000_000C, 0, LW, 1'b0, "inv_after");
        stall_force = 1'b1;
        inv_all     = 1'b1;
        #1;
        n_chk++;
        if (icache_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_idle_same got %b exp 1", icache_ready);
        end
        @(posedge clk);
        #1 inv_all = 1'b0;
        clear_model();
        @(negedge clk);
        stall_force = 1'b0;
        serve_miss(32'h4000_000C, 0, LW, 1'b0, "inv_idle_miss");
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_pc    = 32'h5000_0000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd_rdy = 1'b1;
        @(posedge clk);
        #1 rd_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rd_valid = 1'b1;
            rd_data  = 32'hBAD0_0000 | b;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (icache_ready !== 1'b1 || rd_req !== 1'b0 || icache_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid got rdy=%b req=%b data=%h exp 1 0 0",
                     icache_ready, rd_req, icache_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        for (int c = 0; c < 3; c++) begin
            rd_last = (c == 2);
            @(negedge clk);
            n_chk++;
            if (icache_ready !== 1'b1 || rd_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_beat%0d got rdy=%b req=%b exp 1 0",
                         c, icache_ready, rd_req);
            end
        end
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        rd_data  = '0;
        fetch(32'h5000_0000, 0, LW, 1'b0, "post_rst_miss");
        fetch(32'h1C00_8004, 0, LW, 1'b0, "post_rst_old");
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_pc      = '0;
        inv_all     = 1'b0;
        rd_rdy      = 1'b0;
        rd_valid    = 1'b0;
        rd_data     = '0;
        rd_last     = 1'b0;
        stall_force = 1'b0;
        clear_model();
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_stall();
        test_partial();
        test_inv();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache serving the fetch pipeline. A fetch address is presented in the fetch1 stage and looked up in the following cycle, the fetch2 stage, where the cache drives `icache_ready` and `icache_data`. On a miss the cache refills a full line over a simple burst read bus, then delivers the requested word. While `icache_ready` is low, the pipeline holds fetch2 stalled.

## Interface
Parameters:
- `SETS`, 64: number of lines, power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line, power of two, at least 2.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: fetch1 presents a fetch.
- `req_pc` input 32: fetch address, word aligned; bits [1:0] are ignored.
- `is_stall` input 1: pipeline stall; the fetch2 request register holds its value.
- `inv_all` input 1: invalidate every line (one-cycle pulse).
- `icache_ready` output 1: the fetch2 word is valid. It is 1 when fetch2 holds no request.
- `icache_data` output 32: the fetch2 instruction word.
- `rd_req` output 1: burst read request.
- `rd_addr` output 32: line-aligned burst address.
- `rd_rdy` input 1: the bus accepts the request.
- `rd_valid` input 1: a data beat is present.
- `rd_data` input 32: beat data.
- `rd_last` input 1: final beat of the burst.

## Operation
- Address split: `off` = pc[OFF_W+1:2], `idx` = pc[IDX_W+OFF_W+1:OFF_W+2], `tag` = remaining upper bits. OFF_W = log2(LINE_WORDS) and IDX_W = log2(SETS).
- Storage per set: one valid bit, a tag, and LINE_WORDS data words, all held in flops. Reads are combinational from the s2 register.
- s2 register `{s2_valid, s2_pc}` loads `{req_valid, req_pc}` on every cycle in which `is_stall` = 0 and state = IDLE. It holds otherwise.
- FSM states:
  - IDLE: if `s2_valid` and hit, drive ready = 1 and data = `line[idx][off]`. If `s2_valid` and miss, go to REQ. If `s2_valid` = 0, ready = 1.
  - REQ: `rd_req` = 1, `rd_addr` = {s2_pc[31:OFF_W+2], 0}. On `rd_rdy`, go to DATA.
  - DATA: each `rd_valid` beat writes the refill buffer at beat counter `cnt`, then `cnt`++. When `rd_valid` and `rd_last` are both high, go to FILL.
  - FILL: write buffer, tag and valid bit into set `idx`. Drive ready = 1 with data = `buf[off]`. Go to IDLE.
- Burst beat counter `cnt` is OFF_W bits wide and wraps. Beats arriving after LINE_WORDS have been received are ignored. An early `rd_last` fills the line with the words received so far; unreceived words read as 0.
- `icache_ready` = 0 in REQ and DATA, and during an IDLE miss cycle.
- `inv_all`:
  - In IDLE or REQ, all valid bits clear next edge.
  - In DATA or FILL, it is latched in `inv_pend`. The FILL line is written but not marked valid, the requested word is still delivered, and all valid bits clear on entry to IDLE.
- Simultaneous `inv_all` and a hit in IDLE: the current cycle still reports the hit. Invalidation takes effect next cycle.
- `rd_valid` outside DATA is ignored.

## Timing
- Hit latency: request in fetch1 cycle N gives `icache_ready` = 1 in cycle N+1.
- Miss latency: ready rises in the FILL cycle, which is one cycle after the `rd_last` beat.
- `rd_req` stays high from REQ entry until the cycle in which `rd_rdy` is sampled high.
- `is_stall` = 1 while ready = 1: `icache_data` remains stable, because s2 holds and IDLE re-looks up the same word.
- Reset: state = IDLE, `s2_valid` = 0, all valid = 0, `cnt` = 0, `inv_pend` = 0. Outputs are `icache_ready` = 1, `icache_data` = 0, `rd_req` = 0, `rd_addr` = 0.
- Reset mid-burst: the FSM returns to IDLE immediately. Remaining bus beats arrive outside DATA and are ignored.

## Structure
- The shared package `cpu_defs` holds:
  - `icache_state_t` enum {IDLE, REQ, DATA, FILL};
  - `ICACHE_SETS` and `ICACHE_LINE_WORDS` defaults;
  - address-field helper localparams.
- One sub-module, `icache_refill`, contains the REQ/DATA bus handshake, the beat counter and the line buffer. The top level contains the arrays, the s2 register, the hit logic and the FILL write.

## Test plan
- Cold miss: reset, then `req_pc` = 0x1C008008 with `rd_rdy` delayed 2 cycles and beats 0xA0..0xA3 → `rd_addr` = 0x1C008000; ready rises one cycle after `rd_last` with data 0xA2.
- Hit after fill: next request 0x1C00800C → ready = 1 in cycle N+1, data 0xA3, no `rd_req`.
- Conflict: 0x1C009008 (same idx, different tag) → miss, refill. A subsequent 0x1C008008 misses again.
- `inv_all` during DATA → requested word is delivered. A repeat of the same pc misses.
- `is_stall` held 3 cycles during a hit → `icache_data` stable, no new s2 load, new `req_pc` ignored.
- Async `rst` during DATA, then stray `rd_valid` beats → state IDLE, ready = 1, no array write.
